ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline boundary. Sits directly downstream of the ALU.
//  - Registers the ALU result, store data and control into a 2-entry skid buffer with valid/ready handshake.
//  - Resolves branches/jumps from the ALU compare bit and issues a one-cycle redirect to fetch.
// PARAMETERS
//  DATA_WIDTH  32  width of ALU result, store data, PC and target
//  REG_AW      5   register-file address width (rd)
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  ex_valid     in   1           EX beat present
//  ex_ready     out  1           stage can accept a beat
//  alu_result   in   DATA_WIDTH  ALUResult from ALU
//  store_data   in   DATA_WIDTH  forwarded rs2 value
//  ex_rd        in   REG_AW      destination register
//  ex_ctrl      in   6           {RegWrite,MemtoReg,MemRead,MemWrite,Branch,Jump}
//  ex_target    in   DATA_WIDTH  branch/jump target (PC+imm / rs1+imm)
//  ex_pc4       in   DATA_WIDTH  PC+4 (link value for jumps)
//  flush        in   1           kill all held entries and the incoming beat
//  mem_valid    out  1           head entry valid toward MEM
//  mem_ready    in   1           MEM accepts head entry
//  mem_result   out  DATA_WIDTH  head: ALU result, or PC+4 if Jump
//  mem_wdata    out  DATA_WIDTH  head store data
//  mem_rd       out  REG_AW      head rd
//  mem_ctrl     out  4           head {RegWrite,MemtoReg,MemRead,MemWrite}
//  redirect     out  1           one-cycle pulse: fetch must load redirect_pc
//  redirect_pc  out  DATA_WIDTH  target of the taken branch/jump
// BEHAVIOUR
//  Reset: mem_valid=0, redirect=0, redirect_pc=0, ex_ready=1, every data output=0, both entries invalid.
//  Transfer rules:
//    - ex accept = ex_valid & ex_ready & ~flush & ~redirect.
//    - mem transfer = mem_valid & mem_ready.
//  Occupancy FSM:
//    - EMPTY: accept -> ONE.
//    - ONE: accept & transfer -> ONE (head replaced); accept & ~transfer -> FULL (beat into skid);
//      transfer & ~accept -> EMPTY.
//    - FULL: transfer -> ONE (skid moves to head). ex_ready=0.
//  Outputs:
//    - ex_ready is registered: 1 iff the state is not FULL. No combinational path from mem_ready to ex_ready.
//    - Latency: an accepted beat appears on mem_* the next cycle when the stage was EMPTY, or ONE with transfer.
//    - Order is preserved; the skid entry never overtakes the head.
//    - mem_* fields hold stable while mem_valid & ~mem_ready.
//  Branch resolution (on ex accept only):
//    - taken = (Branch & alu_result[0]) | Jump.
//    - taken -> next cycle redirect=1, redirect_pc=ex_target. Otherwise redirect=0.
//    - redirect_pc holds its value when redirect=0.
//    - Branch beats enter the buffer with ctrl bits zero (bubble toward MEM); Jump beats write PC+4 to rd.
//  Shadow kill: while redirect=1, any ex_valid beat is wrong-path. ex_ready reads 1 and the beat is dropped
//    with no state change and no redirect.
//  Flush:
//    - Takes effect the next cycle: both entries invalid, mem_valid=0, redirect=0, state EMPTY.
//    - Has priority over accept, transfer and redirect in the same cycle.
//  Reset mid-operation behaves like flush and also zeroes the data registers.
//  Widths: all datapaths are DATA_WIDTH unsigned; no arithmetic here (targets are computed upstream).
// STRUCTURE
//  pipeline_pkg:
//    - ex_mem_t packed struct {result, wdata, rd, ctrl}.
//    - ctrl bit-index localparams.
//    - ALU operation codes (AND=0000, OR=0001, ADD=0010, SUB=0110, EQ=1000, NE=1001, LT=1010, GE=1011).
//  Sub-module pipe_skid_buf: generic 2-entry valid/ready skid buffer parameterised on the payload type.
//    ex_mem_stage instantiates it and adds branch resolution and the redirect register.
// TESTING
//  1 Reset held 2 cycles, ex_valid=1 -> mem_valid=0, ex_ready=1, redirect=0; after release, first beat appears 1 cycle later.
//  2 Streaming: ADD result 0x0000_0005, rd=3, mem_ready=1 every cycle -> mem_result=5, mem_rd=3 next cycle; one beat per cycle, no bubbles.
//  3 Backpressure: mem_ready=0 while beats A=0x11, B=0x22, C=0x33 are offered.
//    - A is held at the head and B in the skid; ex_ready=0 the next cycle; C is stalled.
//    - After mem_ready=1, output order is A, B, C with no loss or duplication.
//  4 Branch taken: Branch=1, alu_result=1, ex_target=0x100 -> next cycle redirect=1, redirect_pc=0x100, mem_ctrl=0.
//    - The beat offered during the redirect cycle is dropped.
//    - With alu_result=0 -> redirect stays 0.
//  5 Jump: Jump=1, ex_pc4=0x24, rd=1, ex_target=0x80 -> mem_result=0x24 with RegWrite=1; redirect_pc=0x80.
//  6 Flush with the stage FULL and ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, redirect=0; the incoming beat never reaches MEM.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: EX->MEM payload, control bit positions,
// ALU operation codes and skid-buffer occupancy states.
package pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW_DEF = 5;

  // Bit positions inside the 6-bit EX control bundle
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 1;
  localparam int CTRL_JUMP     = 0;

  // Bit positions inside the 4-bit MEM control bundle
  localparam int MCTRL_REGWRITE = 3;
  localparam int MCTRL_MEMTOREG = 2;
  localparam int MCTRL_MEMREAD  = 1;
  localparam int MCTRL_MEMWRITE = 0;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_EQ  = 4'b1000,
    ALU_NE  = 4'b1001,
    ALU_LT  = 4'b1010,
    ALU_GE  = 4'b1011
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       wdata;
    logic [REG_AW_DEF-1:0] rd;
    logic [3:0]            ctrl;
  } ex_mem_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready depends only on the
// occupancy register, so there is no combinational path from out_ready.
module pipe_skid_buf #(
  parameter type payload_t = logic [31:0]
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);
  import pipeline_pkg::*;

  buf_state_e state, state_next;
  payload_t   head, skid;
  logic       accept, xfer;
  logic       load_head_in, load_head_skid, load_skid_in;

  assign in_ready  = (state != BUF_FULL);
  assign out_valid = (state != BUF_EMPTY);
  assign out_data  = head;
  assign accept    = in_valid & in_ready & ~flush;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          load_head_in = 1'b1;
          state_next   = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && xfer) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          load_skid_in = 1'b1;
          state_next   = BUF_FULL;
        end else if (xfer) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // The skid entry only ever moves into the head, keeping order
        if (xfer) begin
          load_head_skid = 1'b1;
          state_next     = BUF_ONE;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUF_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
      if (load_head_in)
        head <= in_data;
      else if (load_head_skid)
        head <= skid;
      if (load_skid_in)
        skid <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: buffers ALU results in a skid buffer and
// resolves branches/jumps into a one-cycle fetch redirect.
module ex_mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic [5:0]            ex_ctrl,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic [DATA_WIDTH-1:0] ex_pc4,
  input  logic                  flush,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [REG_AW-1:0]     mem_rd,
  output logic [3:0]            mem_ctrl,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] wdata;
    logic [REG_AW-1:0]     rd;
    logic [3:0]            ctrl;
  } payload_t;

  payload_t beat, head;
  logic     buf_ready, accept, taken, is_jump, is_branch;

  assign is_jump   = ex_ctrl[CTRL_JUMP];
  assign is_branch = ex_ctrl[CTRL_BRANCH];
  assign taken     = (is_branch & alu_result[0]) | is_jump;
  assign accept    = ex_valid & buf_ready & ~flush & ~redirect;

  // During the redirect cycle the incoming beat is wrong-path: it is
  // swallowed, so the stage advertises ready regardless of occupancy.
  assign ex_ready = buf_ready | redirect;

  always_comb begin
    beat.result = alu_result;
    beat.wdata  = store_data;
    beat.rd     = ex_rd;
    beat.ctrl   = ex_ctrl[CTRL_REGWRITE:CTRL_MEMWRITE];
    if (is_jump) begin
      beat.result               = ex_pc4;
      beat.ctrl[MCTRL_REGWRITE] = 1'b1;
    end else if (is_branch) begin
      beat.ctrl = 4'b0000;
    end
  end

  pipe_skid_buf #(
    .payload_t (payload_t)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (ex_valid & ~redirect),
    .in_ready  (buf_ready),
    .in_data   (beat),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (head)
  );

  assign mem_result = head.result;
  assign mem_wdata  = head.wdata;
  assign mem_rd     = head.rd;
  assign mem_ctrl   = head.ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else if (flush) begin
      redirect <= 1'b0;
    end else begin
      redirect <= accept & taken;
      if (accept && taken)
        redirect_pc <= ex_target;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_ex_mem_stage;
  import pipeline_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_ctrl;
  logic [31:0] ex_target;
  logic [31:0] ex_pc4;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_rd;
  logic [3:0]  mem_ctrl;
  logic        redirect;
  logic [31:0] redirect_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: in-order FIFO of at most two beats plus redirect state
  ex_mem_t     exp_q[$];
  logic        exp_redirect;
  logic [31:0] exp_rpc;
  logic        exp_data_zero;

  ex_mem_stage #(.DATA_WIDTH(32), .REG_AW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .ex_rd       (ex_rd),
    .ex_ctrl     (ex_ctrl),
    .ex_target   (ex_target),
    .ex_pc4      (ex_pc4),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_result  (mem_result),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_ctrl    (mem_ctrl),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("ex_ready", 32'(ex_ready), 32'((exp_q.size() < 2) || exp_redirect));
    checkOutput("mem_valid", 32'(mem_valid), 32'(exp_q.size() > 0));
    checkOutput("redirect", 32'(redirect), 32'(exp_redirect));
    checkOutput("redirect_pc", redirect_pc, exp_rpc);
    if (exp_q.size() > 0) begin
      checkOutput("mem_result", mem_result, exp_q[0].result);
      checkOutput("mem_wdata", mem_wdata, exp_q[0].wdata);
      checkOutput("mem_rd", 32'(mem_rd), 32'(exp_q[0].rd));
      checkOutput("mem_ctrl", 32'(mem_ctrl), 32'(exp_q[0].ctrl));
    end else if (exp_data_zero) begin
      checkOutput("reset_result", mem_result, 32'h0);
      checkOutput("reset_wdata", mem_wdata, 32'h0);
      checkOutput("reset_rd", 32'(mem_rd), 32'h0);
      checkOutput("reset_ctrl", 32'(mem_ctrl), 32'h0);
    end
  endtask

  // Drive one cycle of inputs, advance the model and check at the negedge
  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                               input logic [4:0] rd, input logic [5:0] ctl,
                               input logic [31:0] tgt, input logic [31:0] pc4,
                               input logic mr, input logic fl, input logic rst);
    ex_mem_t beat;
    logic    acc, xfer, tk;
    ex_valid   = v;
    alu_result = alu;
    store_data = sd;
    ex_rd      = rd;
    ex_ctrl    = ctl;
    ex_target  = tgt;
    ex_pc4     = pc4;
    mem_ready  = mr;
    flush      = fl;
    reset      = rst;

    acc  = v && (exp_q.size() < 2) && !exp_redirect && !fl && !rst;
    xfer = (exp_q.size() > 0) && mr;
    tk   = (ctl[1] && alu[0]) || ctl[0];
    beat.result = ctl[0] ? pc4 : alu;
    beat.wdata  = sd;
    beat.rd     = rd;
    if (ctl[0])      beat.ctrl = {1'b1, ctl[4:2]};
    else if (ctl[1]) beat.ctrl = 4'b0000;
    else             beat.ctrl = ctl[5:2];

    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_redirect  = 1'b0;
      exp_rpc       = 32'h0;
      exp_data_zero = 1'b1;
    end else if (fl) begin
      exp_q.delete();
      exp_redirect = 1'b0;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(beat);
        exp_data_zero = 1'b0;
      end
      exp_redirect = acc && tk;
      if (acc && tk) exp_rpc = tgt;
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input logic mr);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 6'b0, 32'h0, 32'h0, mr, 1'b0, 1'b0);
  endtask

  initial begin
    exp_redirect  = 1'b0;
    exp_rpc       = 32'h0;
    exp_data_zero = 1'b1;
    reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
    alu_result = '0; store_data = '0; ex_rd = '0; ex_ctrl = '0; ex_target = '0; ex_pc4 = '0;
    @(negedge clk);

    // Reset held two cycles with a beat offered
    applyStimulus(1'b1, 32'h9, 32'h0, 5'd2, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h9, 32'h0, 5'd2, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'h0);
    checkOutput("rst_ex_ready", 32'(ex_ready), 32'h1);
    checkOutput("rst_redirect", 32'(redirect), 32'h0);
    applyStimulus(1'b1, 32'h9, 32'h0, 5'd2, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("first_beat_valid", 32'(mem_valid), 32'h1);

    // Streaming with mem_ready high
    applyStimulus(1'b1, 32'h5, 32'hA, 5'd3, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_result", mem_result, 32'h5);
    checkOutput("stream_rd", 32'(mem_rd), 32'd3);
    applyStimulus(1'b1, 32'h6, 32'hB, 5'd4, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7, 32'hC, 5'd5, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_nobubble", mem_result, 32'h7);
    idle(1'b1);

    // Backpressure: A head, B skid, C stalled, then drain in order
    applyStimulus(1'b1, 32'h11, 32'h0, 5'd6, 6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 32'h0, 5'd7, 6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ex_ready", 32'(ex_ready), 32'h0);
    applyStimulus(1'b1, 32'h33, 32'h0, 5'd8, 6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_head_a", mem_result, 32'h11);
    applyStimulus(1'b1, 32'h33, 32'h0, 5'd8, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_head_b", mem_result, 32'h22);
    applyStimulus(1'b1, 32'h33, 32'h0, 5'd8, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_head_c", mem_result, 32'h33);
    idle(1'b1);
    checkOutput("bp_drained", 32'(mem_valid), 32'h0);

    // Taken branch, wrong-path beat in the shadow, then not-taken branch
    applyStimulus(1'b1, 32'h1, 32'h0, 5'd9, 6'b100010, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_redirect", 32'(redirect), 32'h1);
    checkOutput("br_redirect_pc", redirect_pc, 32'h100);
    checkOutput("br_ctrl", 32'(mem_ctrl), 32'h0);
    applyStimulus(1'b1, 32'h77, 32'h0, 5'd10, 6'b100000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("shadow_dropped", 32'(mem_valid), 32'h0);
    checkOutput("shadow_no_redirect", 32'(redirect), 32'h0);
    applyStimulus(1'b1, 32'h0, 32'h0, 5'd9, 6'b000010, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_not_taken", 32'(redirect), 32'h0);
    checkOutput("br_pc_hold", redirect_pc, 32'h100);

    // Jump writes the link value
    applyStimulus(1'b1, 32'h55, 32'h0, 5'd1, 6'b000001, 32'h80, 32'h24, 1'b1, 1'b0, 1'b0);
    checkOutput("jal_result", mem_result, 32'h24);
    checkOutput("jal_regwrite", 32'(mem_ctrl[MCTRL_REGWRITE]), 32'h1);
    checkOutput("jal_redirect_pc", redirect_pc, 32'h80);
    idle(1'b1);

    // Flush with the stage full and a beat offered
    applyStimulus(1'b1, 32'h41, 32'h0, 5'd11, 6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h42, 32'h0, 5'd12, 6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h43, 32'h0, 5'd13, 6'b000001, 32'h300, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_mem_valid", 32'(mem_valid), 32'h0);
    checkOutput("flush_ex_ready", 32'(ex_ready), 32'h1);
    checkOutput("flush_redirect", 32'(redirect), 32'h0);
    idle(1'b1);
    checkOutput("flush_no_leak", 32'(mem_valid), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom),
                    6'($urandom), $urandom, $urandom, 1'($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
